// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Stream, control and result bundle between the serial front end and the detector.
interface seq_detector_prog_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             x_valid;
    logic             x;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap_en;
    logic             clear_cnt;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x_valid, x, pat_load, pat_in, overlap_en, clear_cnt,
        input  match, match_cnt
    );

    modport slave (
        input  x_valid, x, pat_load, pat_in, overlap_en, clear_cnt,
        output match, match_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear takes effect first, then a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control and match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = {PAT_W{1'b1}}
) (
    input logic               clk,
    input logic               reset,
    seq_detector_prog_if.slave bus
);

    localparam int             FW        = fill_w(PAT_W);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
    localparam logic [FW-1:0] FILL_ARM  = FW'(PAT_W - 1);

    logic [PAT_W-1:0] shift_q;
    logic [PAT_W-1:0] pattern_q;
    logic [PAT_W-1:0] window;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             hit;
    logic             match_q;

    assign window = {shift_q[PAT_W-2:0], bus.x};

    assign hit = bus.x_valid && (fill_q >= FILL_ARM) &&
                 (window == pattern_q) && !bus.pat_load;

    // Non-overlapping mode restarts the fill so no suffix bit is reused.
    always_comb begin
        fill_d = fill_q;
        if (hit && !bus.overlap_en) begin
            fill_d = '0;
        end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            fill_q    <= '0;
            pattern_q <= DEFAULT_PAT;
            match_q   <= 1'b0;
        end else if (bus.pat_load) begin
            pattern_q <= bus.pat_in;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            match_q <= hit;
            if (bus.x_valid) begin
                shift_q <= window;
                fill_q  <= fill_d;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (bus.clear_cnt),
        .q     (bus.match_cnt)
    );

    assign bus.match = match_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed scoreboard bench: A uses CNT_W=8, B uses CNT_W=2 for saturation.
module tb_seq_detector_prog;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;

    always #5 clk = ~clk;

    seq_detector_prog_if #(.PAT_W(4), .CNT_W(8)) ifa ();
    seq_detector_prog_if #(.PAT_W(4), .CNT_W(2)) ifb ();

    seq_detector_prog #(.PAT_W(4), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa.slave)
    );

    seq_detector_prog #(.PAT_W(4), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb.slave)
    );

    typedef struct {
        bit       sel;
        logic     m;
        logic [7:0] c;
        string    tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Drive one cycle on the selected DUT, idle the other, queue the expectation.
    task automatic step(input bit sel, input bit rst, input bit xv,
                        input bit xb, input bit pl, input logic [3:0] pin,
                        input bit ov, input bit clr, input bit em,
                        input int ec, input string tag);
        exp_t e;
        @(negedge clk);
        ifa.x_valid = 0; ifa.x = 0; ifa.pat_load = 0; ifa.clear_cnt = 0;
        ifb.x_valid = 0; ifb.x = 0; ifb.pat_load = 0; ifb.clear_cnt = 0;
        reset_a = 0;
        reset_b = 0;
        if (!sel) begin
            reset_a = rst; ifa.x_valid = xv; ifa.x = xb;
            ifa.pat_load = pl; ifa.pat_in = pin;
            ifa.overlap_en = ov; ifa.clear_cnt = clr;
        end else begin
            reset_b = rst; ifb.x_valid = xv; ifb.x = xb;
            ifb.pat_load = pl; ifb.pat_in = pin;
            ifb.overlap_en = ov; ifb.clear_cnt = clr;
        end
        e.sel = sel;
        e.m = em;
        e.c = 8'(ec);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic bits(input bit sel, input bit ov, input string s,
                        input string em, input int ec[], input string tag);
        for (int i = 0; i < s.len(); i++) begin
            step(sel, 0, 1, s[i] == "1", 0, 4'h0, ov, 0,
                 em[i] == "1", ec[i], tag);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic       am;
        logic [7:0] ac;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            am = e.sel ? ifb.match : ifa.match;
            ac = e.sel ? {6'b0, ifb.match_cnt} : ifa.match_cnt;
            total++;
            if (am !== e.m || ac !== e.c) begin
                bad++;
                $display("FAIL %s: got match=%0b cnt=%0d, want match=%0b cnt=%0d",
                         e.tag, am, ac, e.m, e.c);
            end
        end
    end

    initial begin
        ifa.x_valid = 0; ifa.x = 0; ifa.pat_load = 0; ifa.pat_in = 0;
        ifa.overlap_en = 1; ifa.clear_cnt = 0;
        ifb.x_valid = 0; ifb.x = 0; ifb.pat_load = 0; ifb.pat_in = 0;
        ifb.overlap_en = 1; ifb.clear_cnt = 0;
        reset_a = 1;
        reset_b = 1;
        repeat (2) @(posedge clk);

        step(0, 1, 0, 0, 0, 4'h0, 1, 0, 0, 0, "reset");

        bits(0, 1, "111111", "000111", '{0, 0, 0, 1, 2, 3}, "t1_ovl");
        step(0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 3, "t1_idle");

        step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, "t2_rst");
        bits(0, 0, "11111111", "00010001",
             '{0, 0, 0, 1, 1, 1, 1, 2}, "t2_novl");

        step(0, 1, 0, 0, 0, 4'h0, 1, 0, 0, 0, "t3_rst");
        step(0, 0, 0, 0, 1, 4'b1011, 1, 0, 0, 0, "t3_load");
        bits(0, 1, "1011011", "0001001",
             '{0, 0, 0, 1, 1, 1, 2}, "t3_ovl");
        step(0, 0, 0, 0, 1, 4'b1011, 0, 1, 0, 0, "t3_reload_clr");
        bits(0, 0, "1011011", "0001000",
             '{0, 0, 0, 1, 1, 1, 1}, "t3_novl");

        step(0, 1, 0, 0, 0, 4'h0, 1, 0, 0, 0, "t4_rst");
        step(0, 0, 0, 0, 1, 4'b1011, 1, 0, 0, 0, "t4_load");
        bits(0, 1, "10", "00", '{0, 0}, "t4_head");
        repeat (3) step(0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0, "t4_gap");
        bits(0, 1, "11", "01", '{0, 1}, "t4_tail");
        step(0, 0, 0, 0, 1, 4'b1011, 1, 0, 0, 1, "t4_reload");
        bits(0, 1, "101", "000", '{1, 1, 1}, "t4_pre");
        step(0, 0, 1, 1, 1, 4'b1011, 1, 0, 0, 1, "t4_load_drop");
        bits(0, 1, "1", "0", '{1}, "t4_after");

        step(1, 1, 0, 0, 0, 4'h0, 1, 0, 0, 0, "t5_rst");
        bits(1, 1, "11111111", "00011111",
             '{0, 0, 0, 1, 2, 3, 3, 3}, "t5_sat");
        step(1, 0, 1, 1, 0, 4'h0, 1, 1, 1, 1, "t5_clr_hit");
        step(1, 0, 0, 0, 0, 4'h0, 1, 1, 0, 0, "t5_clr");

        step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, "t6_rst");
        bits(0, 0, "111", "000", '{0, 0, 0}, "t6_part");
        step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, "t6_midrst");
        bits(0, 0, "11111", "00010", '{0, 0, 0, 1, 1}, "t6_after");

        @(negedge clk);
        ifa.x_valid = 0;
        ifb.x_valid = 0;
        ifa.pat_load = 0;
        ifb.pat_load = 0;
        ifa.clear_cnt = 0;
        ifb.clear_cnt = 0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d, want pending=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
